// File: rtl/id_ex_hazard_pipe.sv
// rtl/id_ex_hazard_pipe.sv - ID/EX register with WB bypass, load-use bubbles, EX hold and flush; STALL_COUNTERS_EN adds perf counters
module id_ex_hazard_pipe #(
    parameter int XLEN             = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int CTRL_W           = 16,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    input  logic [XLEN-1:0]       IN_PC,
    input  logic [REG_ADDR_W-1:0] IN_RS1,
    input  logic [REG_ADDR_W-1:0] IN_RS2,
    input  logic [REG_ADDR_W-1:0] IN_RD,
    input  logic [XLEN-1:0]       IN_DATA1,
    input  logic [XLEN-1:0]       IN_DATA2,
    input  logic [XLEN-1:0]       IN_IMM,
    input  logic [CTRL_W-1:0]     IN_CTRL,
    input  logic                  IN_MEM_READ,
    input  logic                  WB_WRITE_ENABLE,
    input  logic [REG_ADDR_W-1:0] WB_RD,
    input  logic [XLEN-1:0]       WB_WRITE_DATA,
    input  logic                  EX_BUSY,
    input  logic                  FLUSH,
    output logic                  OUT_VALID,
    output logic [XLEN-1:0]       OUT_PC,
    output logic [REG_ADDR_W-1:0] OUT_RD,
    output logic [XLEN-1:0]       OUT_DATA1,
    output logic [XLEN-1:0]       OUT_DATA2,
    output logic [XLEN-1:0]       OUT_IMM,
    output logic [CTRL_W-1:0]     OUT_CTRL,
    output logic                  OUT_MEM_READ,
    output logic                  STALL_IF
`ifdef STALL_COUNTERS_EN
    ,
    output logic [31:0]           PERF_STALL_CYC,
    output logic [31:0]           PERF_FLUSH_CNT
`endif
);

    if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 3) begin : g_param_check
        $error("id_ex_hazard_pipe: LOAD_USE_BUBBLES must be 1..3");
    end

    typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

    localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_USE_BUBBLES - 1);

    state_t          state;
    logic [1:0]      count;
    logic            hazard;
    logic [XLEN-1:0] data1_byp;
    logic [XLEN-1:0] data2_byp;

    // WB writes land in the register file after ID read it, so forward them here
    always_comb begin
        data1_byp = IN_DATA1;
        data2_byp = IN_DATA2;
        if (WB_WRITE_ENABLE && WB_RD != '0 && WB_RD == IN_RS1) data1_byp = WB_WRITE_DATA;
        if (WB_WRITE_ENABLE && WB_RD != '0 && WB_RD == IN_RS2) data2_byp = WB_WRITE_DATA;
    end

    assign hazard = (state == ST_RUN) && IN_VALID && OUT_VALID && OUT_MEM_READ &&
                    (OUT_RD != '0) && (OUT_RD == IN_RS1 || OUT_RD == IN_RS2);

    assign STALL_IF = !FLUSH && (EX_BUSY || hazard || state == ST_BUBBLE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            OUT_VALID    <= 1'b0;
            OUT_PC       <= '0;
            OUT_RD       <= '0;
            OUT_DATA1    <= '0;
            OUT_DATA2    <= '0;
            OUT_IMM      <= '0;
            OUT_CTRL     <= '0;
            OUT_MEM_READ <= 1'b0;
            state        <= ST_RUN;
            count        <= '0;
        end else if (FLUSH) begin
            OUT_VALID    <= 1'b0;
            OUT_CTRL     <= '0;
            OUT_MEM_READ <= 1'b0;
            state        <= ST_RUN;
            count        <= '0;
        end else if (!EX_BUSY) begin
            if (hazard || state == ST_BUBBLE) begin
                // Data registers keep stale values; only valid/ctrl make it a bubble
                OUT_VALID    <= 1'b0;
                OUT_CTRL     <= '0;
                OUT_MEM_READ <= 1'b0;
                if (state == ST_RUN) begin
                    if (LOAD_USE_BUBBLES > 1) begin
                        state <= ST_BUBBLE;
                        count <= BUBBLE_INIT;
                    end
                end else begin
                    count <= count - 2'd1;
                    if (count == 2'd1) state <= ST_RUN;
                end
            end else begin
                OUT_VALID    <= IN_VALID;
                OUT_PC       <= IN_PC;
                OUT_RD       <= IN_RD;
                OUT_DATA1    <= data1_byp;
                OUT_DATA2    <= data2_byp;
                OUT_IMM      <= IN_IMM;
                OUT_CTRL     <= IN_CTRL;
                OUT_MEM_READ <= IN_MEM_READ;
            end
        end
    end

`ifdef STALL_COUNTERS_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            PERF_STALL_CYC <= '0;
            PERF_FLUSH_CNT <= '0;
        end else begin
            if (STALL_IF) PERF_STALL_CYC <= PERF_STALL_CYC + 32'd1;
            if (FLUSH)    PERF_FLUSH_CNT <= PERF_FLUSH_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// tb/tb_id_ex_hazard_pipe.sv - directed bench for id_ex_hazard_pipe with 1 and 3 load-use bubbles
module tb_id_ex_hazard_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic [31:0] IN_PC;
    logic [4:0]  IN_RS1, IN_RS2, IN_RD;
    logic [31:0] IN_DATA1, IN_DATA2, IN_IMM;
    logic [15:0] IN_CTRL;
    logic        IN_MEM_READ;
    logic        WB_WRITE_ENABLE;
    logic [4:0]  WB_RD;
    logic [31:0] WB_WRITE_DATA;
    logic        EX_BUSY, FLUSH;

    logic        v1, mr1, st1, v3, mr3, st3;
    logic [31:0] pc1, d11, d21, imm1, pc3, d13, d23, imm3;
    logic [4:0]  rd1, rd3;
    logic [15:0] ctrl1, ctrl3;
`ifdef STALL_COUNTERS_EN
    logic [31:0] ps1, pf1, ps3, pf3;
`endif

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    id_ex_hazard_pipe #(.LOAD_USE_BUBBLES(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_PC(IN_PC), .IN_RS1(IN_RS1),
        .IN_RS2(IN_RS2), .IN_RD(IN_RD), .IN_DATA1(IN_DATA1), .IN_DATA2(IN_DATA2),
        .IN_IMM(IN_IMM), .IN_CTRL(IN_CTRL), .IN_MEM_READ(IN_MEM_READ),
        .WB_WRITE_ENABLE(WB_WRITE_ENABLE), .WB_RD(WB_RD), .WB_WRITE_DATA(WB_WRITE_DATA),
        .EX_BUSY(EX_BUSY), .FLUSH(FLUSH), .OUT_VALID(v1), .OUT_PC(pc1), .OUT_RD(rd1),
        .OUT_DATA1(d11), .OUT_DATA2(d21), .OUT_IMM(imm1), .OUT_CTRL(ctrl1),
        .OUT_MEM_READ(mr1), .STALL_IF(st1)
`ifdef STALL_COUNTERS_EN
        , .PERF_STALL_CYC(ps1), .PERF_FLUSH_CNT(pf1)
`endif
    );

    id_ex_hazard_pipe #(.LOAD_USE_BUBBLES(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_PC(IN_PC), .IN_RS1(IN_RS1),
        .IN_RS2(IN_RS2), .IN_RD(IN_RD), .IN_DATA1(IN_DATA1), .IN_DATA2(IN_DATA2),
        .IN_IMM(IN_IMM), .IN_CTRL(IN_CTRL), .IN_MEM_READ(IN_MEM_READ),
        .WB_WRITE_ENABLE(WB_WRITE_ENABLE), .WB_RD(WB_RD), .WB_WRITE_DATA(WB_WRITE_DATA),
        .EX_BUSY(EX_BUSY), .FLUSH(FLUSH), .OUT_VALID(v3), .OUT_PC(pc3), .OUT_RD(rd3),
        .OUT_DATA1(d13), .OUT_DATA2(d23), .OUT_IMM(imm3), .OUT_CTRL(ctrl3),
        .OUT_MEM_READ(mr3), .STALL_IF(st3)
`ifdef STALL_COUNTERS_EN
        , .PERF_STALL_CYC(ps3), .PERF_FLUSH_CNT(pf3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                      input logic [15:0] ctrl, input logic mr);
        IN_VALID = v; IN_PC = pc; IN_RS1 = rs1; IN_RS2 = rs2; IN_RD = rd;
        IN_DATA1 = a; IN_DATA2 = b; IN_IMM = pc + 32'h100; IN_CTRL = ctrl; IN_MEM_READ = mr;
        #1;
    endtask

    initial begin
        // Reset with random ID/WB inputs
        RST = 1'b0; EX_BUSY = 1'b0; FLUSH = 1'b0;
        WB_WRITE_ENABLE = 1'b1; WB_RD = 5'($urandom); WB_WRITE_DATA = $urandom;
        id(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, 16'($urandom), 1'b1);
        tick; tick;
        chk("rst_valid", {31'd0, v3}, 32'd0);
        chk("rst_pc", pc3, 32'd0);
        chk("rst_data1", d13, 32'd0);
        chk("rst_imm", imm1, 32'd0);
        chk("rst_ctrl", {16'd0, ctrl1}, 32'd0);
        chk("rst_memrd", {31'd0, mr3}, 32'd0);
        chk("rst_stall1", {31'd0, st1}, 32'd0);
        chk("rst_stall3", {31'd0, st3}, 32'd0);
`ifdef STALL_COUNTERS_EN
        chk("rst_perf_stall", ps3, 32'd0);
        chk("rst_perf_flush", pf3, 32'd0);
`endif

        // ADD x1,x2,x3 at PC 0x4
        RST = 1'b1; WB_WRITE_ENABLE = 1'b0;
        id(1'b1, 32'h4, 5'd2, 5'd3, 5'd1, 32'h22, 32'h33, 16'h0011, 1'b0);
        tick;
        chk("add_valid", {31'd0, v1}, 32'd1);
        chk("add_pc", pc1, 32'h4);
        chk("add_rd", {27'd0, rd3}, 32'd1);
        chk("add_data2", d23, 32'h33);
        chk("add_imm", imm3, 32'h104);
        chk("add_ctrl", {16'd0, ctrl3}, 32'h11);

        // Bypass RS1, no bypass with WB_RD=0, bypass RS2
        WB_WRITE_ENABLE = 1'b1; WB_RD = 5'd2; WB_WRITE_DATA = 32'hA;
        id(1'b1, 32'h8, 5'd2, 5'd7, 5'd4, 32'h5, 32'h9, 16'h0011, 1'b0);
        tick;
        chk("byp1_data1", d11, 32'hA);
        chk("byp1_data2", d21, 32'h9);
        WB_RD = 5'd0;
        tick;
        chk("byp_rd0_data1", d13, 32'h5);
        WB_RD = 5'd7;
        tick;
        chk("byp2_data1", d11, 32'h5);
        chk("byp2_data2", d23, 32'hA);
        WB_WRITE_ENABLE = 1'b0;

        // IN_VALID=0 loads a bubble
        id(1'b0, 32'hC, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0011, 1'b0);
        tick;
        chk("inv_valid", {31'd0, v3}, 32'd0);

        // LW x0 followed by a use of x0: no hazard
        id(1'b1, 32'hC, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0203, 1'b1);
        tick;
        id(1'b1, 32'h10, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 16'h0011, 1'b0);
        chk("rd0_nohaz", {31'd0, st3}, 32'd0);

        // Load-use: LW x5 then ADD x6,x5,x1
        id(1'b1, 32'h10, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 16'h0203, 1'b1);
        tick;
        chk("lw_memrd", {31'd0, mr3}, 32'd1);
        id(1'b1, 32'h14, 5'd5, 5'd1, 5'd6, 32'h55, 32'h11, 16'h0011, 1'b0);
        chk("lu_stall1_c0", {31'd0, st1}, 32'd1);
        chk("lu_stall3_c0", {31'd0, st3}, 32'd1);
        tick;
        chk("lu_bub_valid1", {31'd0, v1}, 32'd0);
        chk("lu_bub_valid3", {31'd0, v3}, 32'd0);
        chk("lu_bub_ctrl3", {16'd0, ctrl3}, 32'd0);
        chk("lu_bub_memrd3", {31'd0, mr3}, 32'd0);
        chk("lu_stall1_c1", {31'd0, st1}, 32'd0);
        chk("lu_stall3_c1", {31'd0, st3}, 32'd1);
        tick;
        chk("lu_add_valid1", {31'd0, v1}, 32'd1);
        chk("lu_add_pc1", pc1, 32'h14);
        chk("lu_bub2_valid3", {31'd0, v3}, 32'd0);
        chk("lu_stall3_c2", {31'd0, st3}, 32'd1);
        tick;
        chk("lu_bub3_valid3", {31'd0, v3}, 32'd0);
        chk("lu_stall3_c3", {31'd0, st3}, 32'd0);
        tick;
        chk("lu_add_valid3", {31'd0, v3}, 32'd1);
        chk("lu_add_pc3", pc3, 32'h14);
        chk("lu_add_data1", d13, 32'h55);

        // DIV in EX held busy for 4 cycles
        id(1'b1, 32'h18, 5'd6, 5'd1, 5'd7, 32'h64, 32'h7, 16'h0405, 1'b0);
        tick;
        chk("div_pc", pc3, 32'h18);
        EX_BUSY = 1'b1;
        id(1'b1, 32'h1C, 5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 16'h0011, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_stall3", {31'd0, st3}, 32'd1);
            chk("busy_stall1", {31'd0, st1}, 32'd1);
            tick;
            chk("busy_pc", pc3, 32'h18);
            chk("busy_data1", d11, 32'h64);
            chk("busy_ctrl", {16'd0, ctrl3}, 32'h0405);
        end
        EX_BUSY = 1'b0;
        #1;
        chk("busy_rel_stall", {31'd0, st3}, 32'd0);
        tick;
        chk("busy_rel_pc", pc3, 32'h1C);
        chk("busy_rel_valid", {31'd0, v1}, 32'd1);
`ifdef STALL_COUNTERS_EN
        chk("perf_stall_7", ps3, 32'd7);
`endif

        // FLUSH during BUBBLE
        id(1'b1, 32'h20, 5'd1, 5'd0, 5'd11, 32'h0, 32'h0, 16'h0203, 1'b1);
        tick;
        id(1'b1, 32'h24, 5'd11, 5'd2, 5'd12, 32'h3, 32'h4, 16'h0011, 1'b0);
        chk("fl_haz_stall3", {31'd0, st3}, 32'd1);
        tick;
        FLUSH = 1'b1;
        #1;
        chk("fl_bub_stall3", {31'd0, st3}, 32'd0);
        chk("fl_bub_stall1", {31'd0, st1}, 32'd0);
        tick;
        chk("fl_bub_valid3", {31'd0, v3}, 32'd0);
        chk("fl_bub_valid1", {31'd0, v1}, 32'd0);
`ifdef STALL_COUNTERS_EN
        chk("perf_flush_1", pf3, 32'd1);
        chk("perf_stall_8", ps3, 32'd8);
`endif
        FLUSH = 1'b0;
        #1;
        chk("fl_run_stall3", {31'd0, st3}, 32'd0);
        tick;
        chk("fl_run_valid3", {31'd0, v3}, 32'd1);
        chk("fl_run_pc3", pc3, 32'h24);

        // FLUSH during EX_BUSY
        EX_BUSY = 1'b1; FLUSH = 1'b1;
        #1;
        chk("fl_busy_stall", {31'd0, st3}, 32'd0);
        tick;
        chk("fl_busy_valid", {31'd0, v3}, 32'd0);
        chk("fl_busy_ctrl", {16'd0, ctrl1}, 32'd0);
        EX_BUSY = 1'b0; FLUSH = 1'b0;
        id(1'b1, 32'h30, 5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 16'h0011, 1'b0);
        chk("fl_busy_rel_stall", {31'd0, st3}, 32'd0);
        tick;
        chk("fl_busy_rel_pc", pc3, 32'h30);
        chk("fl_busy_rel_valid", {31'd0, v3}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
